// File: rtl/face_filter_sched.sv
// face_filter_sched
// Chooses which face overlay and filter the display pipeline uses, and
// sequences config changes so they only take effect on frame boundaries.
//
// The candidate config comes from the manual switches when sw_override is
// set. Otherwise, with the microphone enabled, it comes from a band of the
// averaged pitch. Otherwise it is zero. A change is applied only on an
// end-of-frame beat while vga_ready is high. After a pitch-driven change,
// HOLD_FRAMES frames must complete before another change is allowed. Manual
// changes skip that hold.
//
// Ports
//   clk          single clock
//   reset_n      synchronous, active-low reset
//   pitch        unsigned pitch estimate, sampled when pitch_valid & mic_en
//   pitch_valid  pitch is valid this cycle
//   mic_en       microphone-driven selection enabled
//   sw_override  manual selection active
//   sw_face      manual face
//   sw_filter    manual filter
//   pix_valid    pixel-stream beat present (qualifies start_p/end_p)
//   start_p      start-of-frame marker (not used for sequencing)
//   end_p        end-of-frame marker
//   vga_ready    display pipeline can accept a config change
//   face_select  applied face
//   filter_mode  applied filter
//   cfg_update   one-cycle pulse while a config is being applied
//   face_reset   one-cycle pulse when the applied face changes
//   busy         scheduler is not idle
module face_filter_sched #(
    parameter int          HOLD_FRAMES = 8,
    parameter int          AVG_SHIFT   = 3,
    parameter logic [15:0] PITCH_T1    = 16'd200,
    parameter logic [15:0] PITCH_T2    = 16'd400,
    parameter logic [15:0] PITCH_T3    = 16'd800
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [15:0] pitch,
    input  logic       pitch_valid,
    input  logic       mic_en,
    input  logic       sw_override,
    input  logic [1:0] sw_face,
    input  logic [2:0] sw_filter,
    input  logic       pix_valid,
    input  logic       start_p,
    input  logic       end_p,
    input  logic       vga_ready,
    output logic [1:0] face_select,
    output logic [2:0] filter_mode,
    output logic       cfg_update,
    output logic       face_reset,
    output logic       busy
);

    localparam int         ACC_W      = 16 + AVG_SHIFT;
    localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        APPLY,
        HOLD
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   acc;
    logic [15:0]        avg;
    logic [1:0]         band;
    logic [7:0]         hold_cnt;
    logic [1:0]         cand_face;
    logic [2:0]         cand_filter;
    logic               cand_differs;
    logic               end_beat;
    logic               start_unused;

    // start_p carries no sequencing meaning. A beat with both markers set
    // is simply an end-of-frame.
    assign end_beat     = pix_valid & end_p;
    assign start_unused = start_p;

    // The accumulator cannot overflow. acc - (acc >> AVG_SHIFT) is at most
    // 2^ACC_W - 1 - 0xFFFF, so adding a 16-bit pitch still fits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (pitch_valid && mic_en) begin
            acc <= acc - (acc >> AVG_SHIFT) + {{AVG_SHIFT{1'b0}}, pitch};
        end
    end

    assign avg = acc[ACC_W-1 -: 16];

    always_comb begin
        if (avg < PITCH_T1)      band = 2'd0;
        else if (avg < PITCH_T2) band = 2'd1;
        else if (avg < PITCH_T3) band = 2'd2;
        else                     band = 2'd3;
    end

    // Candidate priority: manual switches, then pitch band, then zero.
    always_comb begin
        cand_face   = 2'd0;
        cand_filter = 3'd0;
        if (sw_override) begin
            cand_face   = sw_face;
            cand_filter = sw_filter;
        end else if (mic_en) begin
            cand_face   = band;
            cand_filter = {1'b0, band};
        end
    end

    assign cand_differs = {cand_face, cand_filter} != {face_select, filter_mode};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In PENDING, a reverted candidate wins over a simultaneous frame end.
    // In HOLD, only a manual change may cut the hold short.
    always_comb begin
        state_next = state;
        cfg_update = 1'b0;
        face_reset = 1'b0;
        case (state)
            IDLE: begin
                if (cand_differs) state_next = PENDING;
            end
            PENDING: begin
                if (!cand_differs)                state_next = IDLE;
                else if (end_beat && vga_ready)   state_next = APPLY;
            end
            APPLY: begin
                cfg_update = 1'b1;
                face_reset = (cand_face != face_select);
                state_next = HOLD;
            end
            HOLD: begin
                if (sw_override && cand_differs)  state_next = PENDING;
                else if (hold_cnt >= HOLD_LIMIT)  state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The applied config is only written at the end of APPLY. This keeps
    // it constant for the whole of every frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            face_select <= 2'd0;
            filter_mode <= 3'd0;
        end else if (state == APPLY) begin
            face_select <= cand_face;
            filter_mode <= cand_filter;
        end
    end

    // Counts completed frames during HOLD and saturates at 255.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_cnt <= 8'd0;
        end else if (state == APPLY) begin
            hold_cnt <= 8'd0;
        end else if (state == HOLD && end_beat && hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    assign busy = (state != IDLE) | (start_unused & 1'b0);

endmodule

// File: doc/face_filter_sched.md
FACE_FILTER_SCHED -- requirements
Module: face_filter_sched

Interface
- REQ-001 The module SHALL provide parameter HOLD_FRAMES, default 8: minimum completed frames between two pitch-driven config changes.
- REQ-002 The module SHALL provide parameter AVG_SHIFT, default 3: exponent of the pitch exponential average.
- REQ-003 The module SHALL provide parameters PITCH_T1, PITCH_T2, PITCH_T3, defaults 16'd200, 16'd400, 16'd800: pitch band thresholds, with T1<T2<T3.
- REQ-004 The module SHALL have port clk, input, 1 bit: the single clock.
- REQ-005 The module SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
- REQ-006 The module SHALL have port pitch, input, 16 bits: unsigned pitch estimate.
- REQ-007 The module SHALL have port pitch_valid, input, 1 bit: pitch is valid this cycle.
- REQ-008 The module SHALL have port mic_en, input, 1 bit: microphone control enabled.
- REQ-009 The module SHALL have port sw_override, input, 1 bit: manual selection active.
- REQ-010 The module SHALL have port sw_face, input, 2 bits: manual face.
- REQ-011 The module SHALL have port sw_filter, input, 3 bits: manual filter.
- REQ-012 The module SHALL have port pix_valid, input, 1 bit: a pixel-stream beat is present.
- REQ-013 The module SHALL have port start_p, input, 1 bit: start-of-frame marker, qualified by pix_valid.
- REQ-014 The module SHALL have port end_p, input, 1 bit: end-of-frame marker, qualified by pix_valid.
- REQ-015 The module SHALL have port vga_ready, input, 1 bit: the display pipeline accepts a config change.
- REQ-016 The module SHALL have port face_select, output, 2 bits: applied face.
- REQ-017 The module SHALL have port filter_mode, output, 3 bits: applied filter.
- REQ-018 The module SHALL have port cfg_update, output, 1 bit: one-cycle pulse when the config is applied.
- REQ-019 The module SHALL have port face_reset, output, 1 bit: one-cycle pulse when face_select changes.
- REQ-020 The module SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
- REQ-021 Pitch averaging SHALL use a (16+AVG_SHIFT)-bit accumulator acc, updated only when pitch_valid and mic_en: acc <= acc - (acc>>AVG_SHIFT) + pitch; avg = acc>>AVG_SHIFT (16 bits); the accumulator SHALL NOT overflow.
- REQ-022 Pitch band SHALL be: 0 if avg<T1; 1 if avg<T2; 2 if avg<T3; otherwise 3.
- REQ-023 The candidate config SHALL be chosen in this priority order:
  - sw_override=1: {sw_face, sw_filter};
  - else mic_en=1: face=band, filter={1'b0,band};
  - else face=0, filter=0.
- REQ-024 The FSM SHALL have states IDLE, PENDING, APPLY, HOLD.
- REQ-025 IDLE SHALL go to PENDING when the candidate differs from the applied config.
- REQ-026 PENDING SHALL return to IDLE when the candidate equals the applied config again, and this SHALL take priority.
- REQ-027 PENDING SHALL otherwise go to APPLY on a cycle with pix_valid & end_p & vga_ready; without vga_ready it SHALL stay in PENDING.
- REQ-028 APPLY SHALL last exactly one cycle:
  - latch the candidate sampled in that cycle into face_select/filter_mode (visible the next cycle);
  - cfg_update=1;
  - face_reset=1 only if the face value changes;
  - clear the frame counter;
  - go to HOLD.
- REQ-029 HOLD SHALL increment a saturating 8-bit frame counter on each pix_valid & end_p.
- REQ-030 HOLD SHALL exit to IDLE when the counter reaches HOLD_FRAMES.
- REQ-031 HOLD SHALL go directly to PENDING when sw_override=1 and the candidate differs from the applied config; manual changes SHALL bypass the hold.
- REQ-032 start_p SHALL be ignored for sequencing; if start_p and end_p are both set on one beat, that beat SHALL count as an end-of-frame.
- REQ-033 end_p without pix_valid SHALL be ignored.
- REQ-034 Config outputs SHALL change only in the cycle after APPLY, so a frame never mixes configs.
- REQ-035 cfg_update and face_reset SHALL never be high for two consecutive cycles.

Reset
- REQ-036 While reset_n=0 on a rising clk edge: acc=0, state=IDLE, frame counter=0, face_select=0, filter_mode=0, cfg_update=0, face_reset=0, busy=0.
- REQ-037 Reset asserted mid-PENDING or mid-HOLD SHALL abandon the change, and outputs SHALL return to the values in REQ-036 on the next edge.

Verification
- REQ-038 The bench SHALL cover override apply: sw_override=1, sw_face=2, sw_filter=5, vga_ready=1, then an end_p beat -> next cycle face_select=2, filter_mode=5, cfg_update and face_reset pulse 1 cycle.
- REQ-039 The bench SHALL cover the pitch band: mic_en=1, pitch=500 valid every cycle for 64 cycles, then an end_p beat -> face_select=2, filter_mode=2.
- REQ-040 The bench SHALL cover the hold window: pitch switches to 1000 immediately after an apply -> no cfg_update until 8 end_p beats have occurred, then an apply at the following end_p with face_select=3.
- REQ-041 The bench SHALL cover vga_ready gating: PENDING with vga_ready=0 across 3 end_p beats -> no apply and busy=1; vga_ready=1 at the 4th end_p -> apply.
- REQ-042 The bench SHALL cover candidate revert: candidate changes then returns to the applied config before any end_p -> state IDLE, no pulses.
- REQ-043 The bench SHALL cover reset mid-HOLD: reset_n=0 for 1 cycle at hold count 4 -> all outputs 0, state IDLE, acc=0.
